iic_reg_seq: RTL and testbench

Register-access sequencer that sits directly upstream of the I2C master's command port. It accepts one register read or write request at a time (7-bit device address, 8-bit register address, 8-bit data). It expands the request into the primitive I2C command sequence (START / WRITE byte / READ byte / STOP), waits for each command's response, and reports read data plus a completion status. It replaces hand-written per-operation drivers feeding the interconnect with one reusable, checked engine.

---
 rtl/iic_reg_seq.sv | 160 ++++++++++++++++
 tb/tb_iic_reg_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iic_reg_seq.sv
// rtl/iic_reg_seq.sv - register read/write sequencer feeding an I2C master command port
// Expands one latched request into START/WRITE/READ/STOP commands, one outstanding at a time.
module iic_reg_seq #(
    parameter int ASIZE   = 7,
    parameter int TIMEOUT = 65535
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [ASIZE-1:0] req_dev,
    input  logic [7:0]       req_reg,
    input  logic [7:0]       req_wdata,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [7:0]       cmd_data,
    input  logic             rsp_valid,
    input  logic             rsp_nack,
    input  logic [7:0]       rsp_data,
    output logic             done_valid,
    output logic [1:0]       done_err,
    output logic [7:0]       done_rdata,
    output logic             busy
);
    localparam logic [1:0]  OP_START    = 2'd0;
    localparam logic [1:0]  OP_WRITE    = 2'd1;
    localparam logic [1:0]  OP_READ     = 2'd2;
    localparam logic [1:0]  OP_STOP     = 2'd3;
    localparam logic [1:0]  ERR_OK      = 2'd0;
    localparam logic [1:0]  ERR_NACK    = 2'd1;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_DONE} state_t;

    state_t           state, state_n;
    logic [2:0]       step, step_n;
    logic [1:0]       err, err_n;
    logic [7:0]       rdata, rdata_n;
    logic [15:0]      cnt, cnt_n;
    logic             rw_q;
    logic [ASIZE-1:0] dev_q;
    logic [7:0]       reg_q, wdata_q;
    logic [2:0]       last_step;
    logic [9:0]       cur_cmd, next_cmd;

    // {op, data} for a step; steps 3..4 differ between write and read sequences
    function automatic logic [9:0] step_cmd(input logic [2:0] s, input logic rw,
                                            input logic [ASIZE-1:0] dev,
                                            input logic [7:0] rg, input logic [7:0] wd);
        logic [9:0] c;
        case (s)
            3'd0:    c = {OP_START, 8'h00};
            3'd1:    c = {OP_WRITE, 8'({dev, 1'b0})};
            3'd2:    c = {OP_WRITE, rg};
            3'd3:    c = rw ? {OP_START, 8'h00} : {OP_WRITE, wd};
            3'd4:    c = rw ? {OP_WRITE, 8'({dev, 1'b1})} : {OP_STOP, 8'h00};
            3'd5:    c = {OP_READ, 8'h01};
            default: c = {OP_STOP, 8'h00};
        endcase
        return c;
    endfunction

    assign last_step = rw_q ? 3'd6 : 3'd4;
    assign cur_cmd   = step_cmd(step, rw_q, dev_q, reg_q, wdata_q);
    assign next_cmd  = step_cmd(step_n, rw_q, dev_q, reg_q, wdata_q);

    always_comb begin
        state_n = state;
        step_n  = step;
        err_n   = err;
        rdata_n = rdata;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n = S_CMD;
                    step_n  = 3'd0;
                    err_n   = ERR_OK;
                    rdata_n = 8'h00;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_n = S_RSP;
                    cnt_n   = 16'd0;
                end
            end
            S_RSP: begin
                cnt_n = cnt + 16'd1;
                if (rsp_valid) begin
                    if (cur_cmd[9:8] == OP_READ) rdata_n = rsp_data;
                    if (step == last_step) begin
                        state_n = S_DONE;
                    end else if (cur_cmd[9:8] == OP_WRITE && rsp_nack) begin
                        err_n   = ERR_NACK;
                        step_n  = last_step;
                        state_n = S_CMD;
                    end else begin
                        step_n  = step + 3'd1;
                        state_n = S_CMD;
                    end
                end else if (cnt == CNT_LAST) begin
                    // a timed-out STOP after a NACK still reports the timeout
                    err_n   = ERR_TIMEOUT;
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= 3'd0;
            err        <= ERR_OK;
            rdata      <= 8'h00;
            cnt        <= 16'd0;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= 8'h00;
            wdata_q    <= 8'h00;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_op     <= OP_START;
            cmd_data   <= 8'h00;
            done_valid <= 1'b0;
            done_err   <= ERR_OK;
            done_rdata <= 8'h00;
        end else begin
            state <= state_n;
            step  <= step_n;
            err   <= err_n;
            rdata <= rdata_n;
            cnt   <= cnt_n;
            if (state == S_IDLE && req_valid) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
            // outputs are registered copies of the next-state decode
            req_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            cmd_valid <= (state_n == S_CMD);
            if (state_n == S_CMD) begin
                cmd_op   <= next_cmd[9:8];
                cmd_data <= next_cmd[7:0];
            end
            done_valid <= (state_n == S_DONE);
            done_err   <= (state_n == S_DONE) ? err_n : ERR_OK;
            done_rdata <= (state_n == S_DONE && err_n == ERR_OK) ? rdata_n : 8'h00;
        end
    end
endmodule

// File: tb/tb_iic_reg_seq.sv
// tb/tb_iic_reg_seq.sv - self-checking bench for iic_reg_seq
// Reference model lists the expected command sequence per request; a bench-side master answers.
module tb_iic_reg_seq;
    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_nack;
    logic [7:0] rsp_data;
    logic       done_valid;
    logic [1:0] done_err;
    logic [7:0] done_rdata;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];

    iic_reg_seq #(.ASIZE(7), .TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
        .done_valid(done_valid), .done_err(done_err), .done_rdata(done_rdata),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_op", 32'(cmd_op), 0);
        chk("rst_cmd_data", 32'(cmd_data), 0);
        chk("rst_done_valid", 32'(done_valid), 0);
        chk("rst_done_err", 32'(done_err), 0);
        chk("rst_done_rdata", 32'(done_rdata), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // Command list: full sequence, cut after an unanswered command, or after a NACKed write plus STOP.
    task automatic build_model(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd, input int nack_idx, input int norsp_idx,
                               output int err);
        logic [9:0] full[$];
        exp_q.delete();
        full.push_back({2'd0, 8'h00});
        full.push_back({2'd1, dev, 1'b0});
        full.push_back({2'd1, rg});
        if (rw) begin
            full.push_back({2'd0, 8'h00});
            full.push_back({2'd1, dev, 1'b1});
            full.push_back({2'd2, 8'h01});
        end else begin
            full.push_back({2'd1, wd});
        end
        full.push_back({2'd3, 8'h00});
        err = 0;
        for (int i = 0; i < full.size(); i++) begin
            exp_q.push_back(full[i]);
            if (exp_q.size() - 1 == norsp_idx) begin
                err = 2;
                return;
            end
            if (full[i][9:8] == 2'd1 && exp_q.size() - 1 == nack_idx) begin
                err = 1;
                exp_q.push_back({2'd3, 8'h00});
                if (exp_q.size() - 1 == norsp_idx) err = 2;
                return;
            end
        end
    endtask

    task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rd,
                           input int nack_idx, input int norsp_idx,
                           input int stall_idx, input int stall_len, input int max_lat,
                           input bit hold, input bit do_rst, input int exp_total, input int exp_wait);
        int err, t0, idx, rsp_cyc, exp_done, exp_cmd, stall_left, w;
        bit waiting, fin, fresh;
        logic [9:0] pend;
        logic [7:0] exp_rd;
        build_model(rw, dev, rg, wd, nack_idx, norsp_idx, err);
        exp_rd = (rw && err == 0) ? rd : 8'h00;
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", 32'(w), 32'(exp_wait));
        t0 = cyc;
        tick();
        if (!hold) req_valid = 1'b0;
        req_rw = 1'($urandom); req_dev = 7'($urandom);
        req_reg = 8'($urandom); req_wdata = 8'($urandom);
        idx = 0; waiting = 0; fin = 0; fresh = 1; pend = '0;
        exp_cmd = t0 + 1; exp_done = -1; rsp_cyc = -1; stall_left = stall_len;
        for (int k = 0; k < 300 && !fin; k++) begin
            cmd_ready = 1'b0; rsp_valid = 1'b0;
            rsp_nack = 1'($urandom); rsp_data = 8'($urandom);
            chk("busy", 32'(busy), 1);
            chk("req_ready_busy", 32'(req_ready), 0);
            if (done_valid) begin
                chk("done_cyc", 32'(cyc), 32'(exp_done));
                chk("done_err", 32'(done_err), 32'(err));
                chk("done_rdata", 32'(done_rdata), 32'(exp_rd));
                chk("cmd_count", 32'(idx), 32'(exp_q.size()));
                chk("done_no_cmd", 32'(cmd_valid), 0);
                if (exp_total >= 0) chk("total_latency", 32'(cyc - t0), 32'(exp_total));
                fin = 1;
            end else if (waiting) begin
                chk("one_outstanding", 32'(cmd_valid), 0);
                if (cyc == rsp_cyc) begin
                    rsp_valid = 1'b1;
                    if (pend[9:8] == 2'd1) rsp_nack = (idx - 1 == nack_idx);
                    if (pend[9:8] == 2'd2) rsp_data = rd;
                    waiting = 0;
                    if (idx >= exp_q.size()) exp_done = cyc + 1;
                    else exp_cmd = cyc + 1;
                end
            end else if (cmd_valid) begin
                if (fresh) begin
                    chk("cmd_cyc", 32'(cyc), 32'(exp_cmd));
                    if (idx < exp_q.size()) chk("cmd", 32'({cmd_op, cmd_data}), 32'(exp_q[idx]));
                    else chk("extra_cmd", 32'(idx), 32'(exp_q.size()));
                    pend = {cmd_op, cmd_data};
                    fresh = 0;
                end else begin
                    chk("cmd_stable", 32'({cmd_op, cmd_data}), 32'(pend));
                end
                if (idx == stall_idx && stall_left > 0) begin
                    stall_left--;
                    rsp_valid = 1'($urandom);
                end else if (do_rst && idx == stall_idx) begin
                    rst = 1'b1;
                    #1;
                    chk_reset_outputs();
                    #1;
                    rst = 1'b0;
                    rsp_valid = 1'b0;
                    return;
                end else begin
                    cmd_ready = 1'b1;
                    waiting = 1;
                    fresh = 1;
                    if (idx == norsp_idx) exp_done = cyc + TO + 1;
                    else rsp_cyc = cyc + int'($urandom_range(max_lat, 1));
                    idx++;
                end
            end
            if (!fin) tick();
        end
        chk("finished", 32'(fin), 1);
        cmd_ready = 1'b0; rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0; req_wdata = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();
        // ideal write and read, then NACK on the device-address byte
        run_txn(0, 7'h50, 8'h10, 8'h3C, 8'h00, -1, -1, -1, 0, 1, 0, 0, 11, 0);
        run_txn(1, 7'h50, 8'h22, 8'h00, 8'hA5, -1, -1, -1, 0, 1, 0, 0, 15, 1);
        run_txn(0, 7'h50, 8'h10, 8'h3C, 8'h00, 1, -1, -1, 0, 1, 0, 0, 7, 1);
        // no response to START: timeout, no STOP, next request accepted right after
        run_txn(0, 7'h2A, 8'h44, 8'h55, 8'h00, -1, 0, -1, 0, 1, 0, 0, 10, 1);
        // stall the reg-address write of a read for 5 cycles, then reset
        run_txn(1, 7'h33, 8'h7E, 8'h00, 8'h99, -1, -1, 2, 5, 1, 0, 1, -1, 1);
        run_txn(0, 7'h11, 8'h22, 8'h33, 8'h00, -1, -1, -1, 0, 1, 0, 0, 11, 0);
        // back-to-back with req_valid held high
        run_txn(0, 7'h12, 8'h01, 8'hF0, 8'h00, -1, -1, -1, 0, 1, 1, 0, 11, 1);
        run_txn(0, 7'h13, 8'h02, 8'h0F, 8'h00, -1, -1, -1, 0, 1, 0, 0, 11, 1);
        for (int n = 0; n < 24; n++) begin
            bit rw;
            int nk, nr;
            rw = 1'($urandom);
            nk = ($urandom_range(2) == 0) ? int'($urandom_range(6)) : -1;
            nr = ($urandom_range(5) == 0) ? int'($urandom_range(6)) : -1;
            run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nk, nr,
                    int'($urandom_range(6)), int'($urandom_range(3)), int'($urandom_range(4, 1)),
                    1'($urandom), 0, -1, 1);
        end
        req_valid = 1'b0;
        tick();
        tick();
        chk("final_idle_ready", 32'(req_ready), 1);
        chk("final_idle_busy", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
